// File: rtl/ex_mem_pkg.sv
//==============================================================================
// Module : ex_mem_pkg
// Brief  : Shared types, control-bit indices and default widths for EX/MEM.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package ex_mem_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_ADDR_W = 64;
    localparam int DEF_REG_W  = 5;
    localparam int CTRL_W     = 5;

    localparam int CTRL_BRANCH    = 0;
    localparam int CTRL_MEM_READ  = 1;
    localparam int CTRL_MEM_WRITE = 2;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_REG_WRITE = 4;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
        logic mem_read;
        logic branch;
    } ex_mem_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/ex_mem_slot.sv
//==============================================================================
// Module : ex_mem_slot
// Brief  : One EX/MEM payload register set with load / clear / hold.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module ex_mem_slot
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [ADDR_W-1:0] in_br_target,
    input  logic              in_zero,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic              in_pc_src,
    output logic              out_valid,
    output logic [REG_W-1:0]  out_rt,
    output logic [DATA_W-1:0] out_data2,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [ADDR_W-1:0] out_br_target,
    output logic              out_zero,
    output logic [DATA_W-1:0] out_alu_result,
    output logic              out_pc_src
);

    logic              valid_q,      valid_d;
    logic [REG_W-1:0]  rt_q,         rt_d;
    logic [DATA_W-1:0] data2_q,      data2_d;
    ex_mem_ctrl_t      ctrl_q,       ctrl_d;
    logic [ADDR_W-1:0] br_target_q,  br_target_d;
    logic              zero_q,       zero_d;
    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic              pc_src_q,     pc_src_d;

    // Clear wins over load so a squashed slot can never carry live enables.
    always_comb begin
        valid_d      = valid_q;
        rt_d         = rt_q;
        data2_d      = data2_q;
        ctrl_d       = ctrl_q;
        br_target_d  = br_target_q;
        zero_d       = zero_q;
        alu_result_d = alu_result_q;
        pc_src_d     = pc_src_q;
        if (clear) begin
            valid_d  = 1'b0;
            ctrl_d   = '0;
            pc_src_d = 1'b0;
        end else if (load) begin
            valid_d      = 1'b1;
            rt_d         = in_rt;
            data2_d      = in_data2;
            ctrl_d       = ex_mem_ctrl_t'(in_ctrl);
            br_target_d  = in_br_target;
            zero_d       = in_zero;
            alu_result_d = in_alu_result;
            pc_src_d     = in_pc_src;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q      <= 1'b0;
            rt_q         <= '0;
            data2_q      <= '0;
            ctrl_q       <= '0;
            br_target_q  <= '0;
            zero_q       <= 1'b0;
            alu_result_q <= '0;
            pc_src_q     <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            rt_q         <= rt_d;
            data2_q      <= data2_d;
            ctrl_q       <= ctrl_d;
            br_target_q  <= br_target_d;
            zero_q       <= zero_d;
            alu_result_q <= alu_result_d;
            pc_src_q     <= pc_src_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_rt         = rt_q;
    assign out_data2      = data2_q;
    assign out_ctrl       = ctrl_q;
    assign out_br_target  = br_target_q;
    assign out_zero       = zero_q;
    assign out_alu_result = alu_result_q;
    assign out_pc_src     = pc_src_q;

endmodule

`default_nettype wire

// File: rtl/ex_mem_pipe_reg.sv
//==============================================================================
// Module : ex_mem_pipe_reg
// Brief  : EX/MEM pipeline register with valid/ready, stall, flush and a
//          registered branch decision. Define EXMEM_SKID_EN for a one-entry
//          skid buffer with a registered in_ready.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module ex_mem_pipe_reg
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [ADDR_W-1:0] in_br_target,
    input  logic              in_zero,
    input  logic [DATA_W-1:0] in_alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_W-1:0]  out_rt,
    output logic [DATA_W-1:0] out_data2,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [ADDR_W-1:0] out_br_target,
    output logic              out_zero,
    output logic [DATA_W-1:0] out_alu_result,
    output logic              out_pc_src
);

    logic w_in_fire;
    logic w_out_fire;
    logic w_in_pc_src;
    logic w_main_load;
    logic w_main_clear;

    logic [REG_W-1:0]  w_main_rt;
    logic [DATA_W-1:0] w_main_data2;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [ADDR_W-1:0] w_main_br_target;
    logic              w_main_zero;
    logic [DATA_W-1:0] w_main_alu_result;
    logic              w_main_pc_src;

    assign w_in_fire   = in_valid & in_ready;
    assign w_out_fire  = out_valid & out_ready;
    assign w_in_pc_src = in_ctrl[CTRL_BRANCH] & in_zero;

`ifdef EXMEM_SKID_EN
    logic              w_skid_valid;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic              w_main_open;
    logic [REG_W-1:0]  w_skid_rt;
    logic [DATA_W-1:0] w_skid_data2;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [ADDR_W-1:0] w_skid_br_target;
    logic              w_skid_zero;
    logic [DATA_W-1:0] w_skid_alu_result;
    logic              w_skid_pc_src;

    // Ready depends only on skid occupancy, breaking the out_ready->in_ready path.
    assign in_ready     = ~w_skid_valid;
    assign w_main_open  = ~out_valid | out_ready;
    assign w_main_load  = w_main_open & (w_skid_valid | w_in_fire) & ~flush;
    assign w_main_clear = flush | (w_out_fire & ~w_skid_valid & ~w_in_fire);
    assign w_skid_load  = w_in_fire & out_valid & ~out_ready & ~flush;
    assign w_skid_clear = flush | (w_skid_valid & out_ready);

    assign w_main_rt         = w_skid_valid ? w_skid_rt         : in_rt;
    assign w_main_data2      = w_skid_valid ? w_skid_data2      : in_data2;
    assign w_main_ctrl       = w_skid_valid ? w_skid_ctrl       : in_ctrl;
    assign w_main_br_target  = w_skid_valid ? w_skid_br_target  : in_br_target;
    assign w_main_zero       = w_skid_valid ? w_skid_zero       : in_zero;
    assign w_main_alu_result = w_skid_valid ? w_skid_alu_result : in_alu_result;
    assign w_main_pc_src     = w_skid_valid ? w_skid_pc_src     : w_in_pc_src;

    ex_mem_slot #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .REG_W  (REG_W)
    ) u_skid (
        .clock          (clock),
        .reset          (reset),
        .load           (w_skid_load),
        .clear          (w_skid_clear),
        .in_rt          (in_rt),
        .in_data2       (in_data2),
        .in_ctrl        (in_ctrl),
        .in_br_target   (in_br_target),
        .in_zero        (in_zero),
        .in_alu_result  (in_alu_result),
        .in_pc_src      (w_in_pc_src),
        .out_valid      (w_skid_valid),
        .out_rt         (w_skid_rt),
        .out_data2      (w_skid_data2),
        .out_ctrl       (w_skid_ctrl),
        .out_br_target  (w_skid_br_target),
        .out_zero       (w_skid_zero),
        .out_alu_result (w_skid_alu_result),
        .out_pc_src     (w_skid_pc_src)
    );
`else
    assign in_ready     = ~out_valid | out_ready;
    assign w_main_load  = w_in_fire & ~flush;
    assign w_main_clear = flush | (w_out_fire & ~w_in_fire);

    assign w_main_rt         = in_rt;
    assign w_main_data2      = in_data2;
    assign w_main_ctrl       = in_ctrl;
    assign w_main_br_target  = in_br_target;
    assign w_main_zero       = in_zero;
    assign w_main_alu_result = in_alu_result;
    assign w_main_pc_src     = w_in_pc_src;
`endif

    ex_mem_slot #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .REG_W  (REG_W)
    ) u_main (
        .clock          (clock),
        .reset          (reset),
        .load           (w_main_load),
        .clear          (w_main_clear),
        .in_rt          (w_main_rt),
        .in_data2       (w_main_data2),
        .in_ctrl        (w_main_ctrl),
        .in_br_target   (w_main_br_target),
        .in_zero        (w_main_zero),
        .in_alu_result  (w_main_alu_result),
        .in_pc_src      (w_main_pc_src),
        .out_valid      (out_valid),
        .out_rt         (out_rt),
        .out_data2      (out_data2),
        .out_ctrl       (out_ctrl),
        .out_br_target  (out_br_target),
        .out_zero       (out_zero),
        .out_alu_result (out_alu_result),
        .out_pc_src     (out_pc_src)
    );

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_pipe_reg.sv
//==============================================================================
// Module : tb_ex_mem_pipe_reg
// Brief  : Directed self-checking bench for ex_mem_pipe_reg (either build).
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_ex_mem_pipe_reg;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rt;
    logic [63:0] in_data2;
    logic [4:0]  in_ctrl;
    logic [63:0] in_br_target;
    logic        in_zero;
    logic [63:0] in_alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rt;
    logic [63:0] out_data2;
    logic [4:0]  out_ctrl;
    logic [63:0] out_br_target;
    logic        out_zero;
    logic [63:0] out_alu_result;
    logic        out_pc_src;

    int n_checks = 0;
    int n_errors = 0;

    ex_mem_pipe_reg dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rt          (in_rt),
        .in_data2       (in_data2),
        .in_ctrl        (in_ctrl),
        .in_br_target   (in_br_target),
        .in_zero        (in_zero),
        .in_alu_result  (in_alu_result),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rt         (out_rt),
        .out_data2      (out_data2),
        .out_ctrl       (out_ctrl),
        .out_br_target  (out_br_target),
        .out_zero       (out_zero),
        .out_alu_result (out_alu_result),
        .out_pc_src     (out_pc_src)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rt, input logic [4:0] ctrl,
                         input logic z, input logic [63:0] tgt, input logic [63:0] alu);
        in_valid      = v;
        in_rt         = rt;
        in_data2      = {32'hD00D_0000, 27'd0, rt};
        in_ctrl       = ctrl;
        in_zero       = z;
        in_br_target  = tgt;
        in_alu_result = alu;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 5'd31, 5'b11111, 1'b1, 64'hFFFF, 64'hAA);

        // Reset with a valid input held
        step();
        step();
        check("rst_valid", out_valid, 0);
        check("rst_ctrl", out_ctrl, 0);
        check("rst_pc_src", out_pc_src, 0);
        check("rst_alu", out_alu_result, 0);
        check("rst_data2", out_data2, 0);
        check("rst_target", out_br_target, 0);
        check("rst_rt", out_rt, 0);

        reset = 1'b0;
        #1;
        check("post_rst_ready", in_ready, 1);
        step();
        check("first_valid", out_valid, 1);
        check("first_alu", out_alu_result, 64'hAA);
        check("first_pc_src", out_pc_src, 1);

        // Four-instruction stream
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'(i + 1), 5'b10000, 1'b0, 64'h0, 64'(16 * (i + 1)));
            step();
            check("stream_valid", out_valid, 1);
            check("stream_alu", out_alu_result, 64'(16 * (i + 1)));
            check("stream_rt", out_rt, 64'(i + 1));
            check("stream_data2", out_data2, {32'hD00D_0000, 27'd0, 5'(i + 1)});
            check("stream_pc_src", out_pc_src, 0);
        end

        // Branch taken / not taken
        drive(1'b1, 5'd0, 5'b00001, 1'b1, 64'h100, 64'h70);
        step();
        check("br_taken_pc_src", out_pc_src, 1);
        check("br_taken_target", out_br_target, 64'h100);
        drive(1'b1, 5'd0, 5'b00001, 1'b0, 64'h200, 64'h80);
        step();
        check("br_not_taken_pc_src", out_pc_src, 0);
        check("br_not_taken_target", out_br_target, 64'h200);

`ifndef EXMEM_SKID_EN
        // Three-cycle stall: outputs frozen, in_ready low
        out_ready = 1'b0;
        drive(1'b1, 5'd6, 5'b01010, 1'b0, 64'h300, 64'h60);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_in_ready", in_ready, 0);
            step();
            check("stall_valid", out_valid, 1);
            check("stall_alu", out_alu_result, 64'h80);
            check("stall_target", out_br_target, 64'h200);
            check("stall_ctrl", out_ctrl, 5'b00001);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        step();
        check("release_alu", out_alu_result, 64'h60);
        check("release_ctrl", out_ctrl, 5'b01010);
`else
        drive(1'b1, 5'd6, 5'b01010, 1'b0, 64'h300, 64'h60);
        step();
        check("load_alu", out_alu_result, 64'h60);
`endif

        // Drain with no new input: control cleared, data held
        drive(1'b0, 5'd9, 5'b11111, 1'b1, 64'h999, 64'h999);
        step();
        check("drain_valid", out_valid, 0);
        check("drain_ctrl", out_ctrl, 0);
        check("drain_alu_hold", out_alu_result, 64'h60);

        // Flush beats a simultaneous accept
        drive(1'b1, 5'd3, 5'b10001, 1'b1, 64'h400, 64'h90);
        step();
        check("pre_flush_pc_src", out_pc_src, 1);
        flush = 1'b1;
        drive(1'b1, 5'd4, 5'b10001, 1'b1, 64'h500, 64'hA0);
        step();
        flush = 1'b0;
        drive(1'b0, 5'd0, 5'b00000, 1'b0, 64'h0, 64'h0);
        #1;
        check("flush_valid", out_valid, 0);
        check("flush_ctrl", out_ctrl, 0);
        check("flush_pc_src", out_pc_src, 0);
        check("flush_in_ready", in_ready, 1);

`ifdef EXMEM_SKID_EN
        // Two back-to-back inputs into a stalled register
        out_ready = 1'b0;
        drive(1'b1, 5'd1, 5'b10000, 1'b0, 64'h0, 64'h11);
        step();
        check("skid_a_alu", out_alu_result, 64'h11);
        check("skid_a_ready", in_ready, 1);
        drive(1'b1, 5'd2, 5'b01000, 1'b0, 64'h0, 64'h22);
        step();
        check("skid_full_ready", in_ready, 0);
        check("skid_a_hold", out_alu_result, 64'h11);
        drive(1'b1, 5'd3, 5'b00100, 1'b0, 64'h0, 64'h33);
        step();
        check("skid_stall_hold", out_alu_result, 64'h11);
        out_ready = 1'b1;
        drive(1'b0, 5'd0, 5'b00000, 1'b0, 64'h0, 64'h0);
        step();
        check("skid_b_alu", out_alu_result, 64'h22);
        check("skid_b_ctrl", out_ctrl, 5'b01000);
        check("skid_b_ready", in_ready, 1);
        step();
        check("skid_empty_valid", out_valid, 0);

        // Fill main + skid, then flush both
        out_ready = 1'b0;
        drive(1'b1, 5'd1, 5'b10000, 1'b0, 64'h0, 64'h44);
        step();
        drive(1'b1, 5'd2, 5'b10000, 1'b0, 64'h0, 64'h55);
        step();
        check("skid_refill_ready", in_ready, 0);
        drive(1'b0, 5'd0, 5'b00000, 1'b0, 64'h0, 64'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("skid_flush_valid", out_valid, 0);
        check("skid_flush_ready", in_ready, 1);
        out_ready = 1'b1;
        step();
        check("skid_flush_stays_empty", out_valid, 0);
`endif

        // Reset mid-stall
        out_ready = 1'b0;
        drive(1'b1, 5'd7, 5'b11001, 1'b1, 64'h700, 64'h77);
        step();
        check("pre_rst_valid", out_valid, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midstall_rst_valid", out_valid, 0);
        check("midstall_rst_alu", out_alu_result, 0);
        check("midstall_rst_pc_src", out_pc_src, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
